// File: rtl/brq_pkg.sv
// Shared types for the brq core slice: writeback instruction type and the
// writeback queue entry. Optional perf fields are present only when
// BRQ_WB_PERF_EN is defined.
package brq_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  typedef struct packed {
    wb_instr_type_e instr_type;
    logic [31:0]    pc;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    logic           rf_we;
    logic           fp_we;
    logic           fp_load;
`ifdef BRQ_WB_PERF_EN
    logic           compressed;
    logic           perf_count;
`endif
    logic           resp_done;
    logic           resp_err;
  } wb_entry_t;

endpackage

// File: rtl/brq_wb_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for the writeback queue. Depth must be a
// power of two so the pointers wrap by natural overflow.
module brq_wb_fifo_ctrl #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  output logic [PtrW-1:0] wptr_o,
  output logic [PtrW-1:0] rptr_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o
);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next-state for pointers and occupancy; push and pop together leave count unchanged.
  always_comb begin
    wptr_d = push_i ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop_i  ? rptr_q + PtrW'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && !push_i) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CntW'(Depth));

endmodule

// File: rtl/brq_wb_queue.sv
// In-order writeback queue: holds instructions from ID/EX until they can
// retire, matching in-order LSU responses to the oldest waiting LOAD/STORE.
// Define BRQ_WB_PERF_EN to store perf fields and drive the retire counters.
module brq_wb_queue
  import brq_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned OccW  = $clog2(Depth + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_wb_i,
  input  wb_instr_type_e instr_type_wb_i,
  input  logic [31:0]    pc_id_i,
  input  logic [4:0]     rf_waddr_id_i,
  input  logic [31:0]    rf_wdata_id_i,
  input  logic           rf_we_id_i,
  input  logic           fp_rf_wen_id_i,
  input  logic           fp_load_i,
  input  logic           instr_is_compressed_id_i,
  input  logic           instr_perf_count_id_i,
  input  logic           lsu_resp_valid_i,
  input  logic           lsu_resp_err_i,
  input  logic [31:0]    rf_wdata_lsu_i,
  output logic           ready_wb_o,
  output logic           rf_we_wb_o,
  output logic [4:0]     rf_waddr_wb_o,
  output logic [31:0]    rf_wdata_wb_o,
  output logic           fp_rf_wen_wb_o,
  output logic [4:0]     fp_rf_waddr_wb_o,
  output logic [31:0]    fp_rf_wdata_wb_o,
  output logic           instr_done_wb_o,
  output logic [31:0]    pc_wb_o,
  output logic           outstanding_load_wb_o,
  output logic           outstanding_store_wb_o,
  output logic [31:0]    int_pend_mask_o,
  output logic [31:0]    fp_pend_mask_o,
  output logic [OccW-1:0] occupancy_o,
  output logic           perf_instr_ret_wb_o,
  output logic           perf_instr_ret_compressed_wb_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_entry_t        entries_q [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  wptr, rptr, search_idx, resp_idx;
  logic [CntW-1:0]  count;
  logic             full, alloc, retire, resp_hit, head_resp_now, head_valid, head_err;
  logic             int_we, fp_we;
  logic [31:0]      wr_data;
  wb_entry_t        head, new_entry;

  brq_wb_fifo_ctrl #(
    .Depth(Depth)
  ) u_fifo_ctrl (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (alloc),
    .pop_i  (retire),
    .wptr_o (wptr),
    .rptr_o (rptr),
    .count_o(count),
    .full_o (full)
  );

  assign ready_wb_o  = ~full | retire;
  assign alloc       = en_wb_i & ready_wb_o;
  assign occupancy_o = OccW'(count);
  assign head        = entries_q[rptr];
  assign head_valid  = valid_q[rptr];

  // Build the entry written at the tail on allocate.
  always_comb begin
    new_entry            = '0;
    new_entry.instr_type = instr_type_wb_i;
    new_entry.pc         = pc_id_i;
    new_entry.waddr      = rf_waddr_id_i;
    new_entry.wdata      = rf_wdata_id_i;
    new_entry.rf_we      = rf_we_id_i;
    new_entry.fp_we      = fp_rf_wen_id_i;
    new_entry.fp_load    = fp_load_i;
`ifdef BRQ_WB_PERF_EN
    new_entry.compressed = instr_is_compressed_id_i;
    new_entry.perf_count = instr_perf_count_id_i;
`endif
  end

  // Find the oldest valid LOAD/STORE still waiting for its response, walking from the head.
  always_comb begin
    resp_hit   = 1'b0;
    resp_idx   = '0;
    search_idx = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      search_idx = rptr + PtrW'(i);
      if (!resp_hit && lsu_resp_valid_i && valid_q[search_idx] &&
          entries_q[search_idx].instr_type != WB_INSTR_OTHER &&
          !entries_q[search_idx].resp_done) begin
        resp_hit = 1'b1;
        resp_idx = search_idx;
      end
    end
  end

  // Retire decision and register-file write selection for the head entry.
  always_comb begin
    head_resp_now = resp_hit & (resp_idx == rptr);
    retire        = head_valid & ((head.instr_type == WB_INSTR_OTHER) | head.resp_done |
                                  head_resp_now);
    head_err      = (head.instr_type != WB_INSTR_OTHER) &
                    (head_resp_now ? lsu_resp_err_i : head.resp_err);
    int_we        = 1'b0;
    fp_we         = 1'b0;
    wr_data       = head.wdata;
    if (retire) begin
      case (head.instr_type)
        WB_INSTR_OTHER: begin
          int_we = head.rf_we;
          fp_we  = head.fp_we;
        end
        WB_INSTR_LOAD: begin
          if (!head_err) begin
            int_we  = ~head.fp_load;
            fp_we   = head.fp_load;
            wr_data = head_resp_now ? rf_wdata_lsu_i : head.wdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Write ports; x0 writes are dropped.
  always_comb begin
    rf_we_wb_o       = int_we & (head.waddr != 5'd0);
    rf_waddr_wb_o    = rf_we_wb_o ? head.waddr : 5'd0;
    rf_wdata_wb_o    = rf_we_wb_o ? wr_data : 32'd0;
    fp_rf_wen_wb_o   = fp_we;
    fp_rf_waddr_wb_o = fp_we ? head.waddr : 5'd0;
    fp_rf_wdata_wb_o = fp_we ? wr_data : 32'd0;
    instr_done_wb_o  = retire;
    pc_wb_o          = head_valid ? head.pc : 32'd0;
  end

  // Pending-write masks and outstanding-access flags over all valid entries.
  always_comb begin
    int_pend_mask_o        = '0;
    fp_pend_mask_o         = '0;
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_q[i]) begin
        case (entries_q[i].instr_type)
          WB_INSTR_OTHER: begin
            if (entries_q[i].rf_we) int_pend_mask_o[entries_q[i].waddr] = 1'b1;
            if (entries_q[i].fp_we) fp_pend_mask_o[entries_q[i].waddr] = 1'b1;
          end
          WB_INSTR_LOAD: begin
            // A LOAD known to have faulted will not write.
            if (!(entries_q[i].resp_done && entries_q[i].resp_err)) begin
              if (entries_q[i].fp_load) fp_pend_mask_o[entries_q[i].waddr] = 1'b1;
              else                      int_pend_mask_o[entries_q[i].waddr] = 1'b1;
            end
            if (!entries_q[i].resp_done) outstanding_load_wb_o = 1'b1;
          end
          WB_INSTR_STORE: begin
            if (!entries_q[i].resp_done) outstanding_store_wb_o = 1'b1;
          end
          default: ;
        endcase
      end
    end
    int_pend_mask_o[0] = 1'b0;
  end

  // Valid bits: retire clears the head, allocate sets the tail (allocate wins on the same slot).
  always_comb begin
    valid_d = valid_q;
    if (retire) valid_d[rptr] = 1'b0;
    if (alloc)  valid_d[wptr] = 1'b1;
  end

  // Valid-bit state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload storage, left unreset; every read is qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    if (resp_hit) begin
      entries_q[resp_idx].resp_done <= 1'b1;
      entries_q[resp_idx].resp_err  <= lsu_resp_err_i;
      if (entries_q[resp_idx].instr_type == WB_INSTR_LOAD) begin
        entries_q[resp_idx].wdata <= rf_wdata_lsu_i;
      end
    end
    if (alloc) begin
      entries_q[wptr] <= new_entry;
    end
  end

`ifdef BRQ_WB_PERF_EN
  assign perf_instr_ret_wb_o            = retire & head.perf_count & ~head_err;
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head.compressed;
`else
  logic unused_perf_inputs;
  assign unused_perf_inputs             = ^{instr_is_compressed_id_i, instr_perf_count_id_i};
  assign perf_instr_ret_wb_o            = 1'b0;
  assign perf_instr_ret_compressed_wb_o = 1'b0;
`endif

endmodule

// File: tb/tb_brq_wb_queue.sv
// Directed bench for brq_wb_queue (Depth = 4). Inputs change 1 time unit after
// the rising edge; outputs are checked 1 time unit later.
module tb_brq_wb_queue;
  import brq_pkg::*;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           en_wb;
  wb_instr_type_e instr_type;
  logic [31:0]    pc_id, rf_wdata_id, rf_wdata_lsu;
  logic [4:0]     rf_waddr_id;
  logic           rf_we_id, fp_rf_wen_id, fp_load, compressed, perf_count;
  logic           lsu_resp_valid, lsu_resp_err;
  logic           ready_wb, rf_we_wb, fp_rf_wen_wb, instr_done, out_load, out_store;
  logic [4:0]     rf_waddr_wb, fp_rf_waddr_wb;
  logic [31:0]    rf_wdata_wb, fp_rf_wdata_wb, pc_wb, int_mask, fp_mask;
  logic [2:0]     occupancy;
  logic           perf_ret, perf_ret_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  brq_wb_queue #(.Depth(4)) dut (
    .clk_i                          (clk),
    .rst_ni                         (rst_ni),
    .en_wb_i                        (en_wb),
    .instr_type_wb_i                (instr_type),
    .pc_id_i                        (pc_id),
    .rf_waddr_id_i                  (rf_waddr_id),
    .rf_wdata_id_i                  (rf_wdata_id),
    .rf_we_id_i                     (rf_we_id),
    .fp_rf_wen_id_i                 (fp_rf_wen_id),
    .fp_load_i                      (fp_load),
    .instr_is_compressed_id_i       (compressed),
    .instr_perf_count_id_i          (perf_count),
    .lsu_resp_valid_i               (lsu_resp_valid),
    .lsu_resp_err_i                 (lsu_resp_err),
    .rf_wdata_lsu_i                 (rf_wdata_lsu),
    .ready_wb_o                     (ready_wb),
    .rf_we_wb_o                     (rf_we_wb),
    .rf_waddr_wb_o                  (rf_waddr_wb),
    .rf_wdata_wb_o                  (rf_wdata_wb),
    .fp_rf_wen_wb_o                 (fp_rf_wen_wb),
    .fp_rf_waddr_wb_o               (fp_rf_waddr_wb),
    .fp_rf_wdata_wb_o               (fp_rf_wdata_wb),
    .instr_done_wb_o                (instr_done),
    .pc_wb_o                        (pc_wb),
    .outstanding_load_wb_o          (out_load),
    .outstanding_store_wb_o         (out_store),
    .int_pend_mask_o                (int_mask),
    .fp_pend_mask_o                 (fp_mask),
    .occupancy_o                    (occupancy),
    .perf_instr_ret_wb_o            (perf_ret),
    .perf_instr_ret_compressed_wb_o (perf_ret_c)
  );

  task automatic idle();
    en_wb = 1'b0; instr_type = WB_INSTR_OTHER; pc_id = '0; rf_waddr_id = '0;
    rf_wdata_id = '0; rf_we_id = 1'b0; fp_rf_wen_id = 1'b0; fp_load = 1'b0;
    compressed = 1'b0; perf_count = 1'b1;
    lsu_resp_valid = 1'b0; lsu_resp_err = 1'b0; rf_wdata_lsu = '0;
  endtask

  task automatic offer(input wb_instr_type_e t, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] d, input logic we, input logic fwe, input logic fl);
    en_wb = 1'b1; instr_type = t; pc_id = pc; rf_waddr_id = rd; rf_wdata_id = d;
    rf_we_id = we; fp_rf_wen_id = fwe; fp_load = fl;
  endtask

  task automatic respond(input logic [31:0] d, input logic err);
    lsu_resp_valid = 1'b1; rf_wdata_lsu = d; lsu_resp_err = err;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst_ni = 1'b0; #12;
    checks++; if (ready_wb !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", ready_wb); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", occupancy); end
    checks++; if ({instr_done, rf_we_wb, fp_rf_wen_wb, out_load, out_store} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 00000", {instr_done, rf_we_wb, fp_rf_wen_wb, out_load, out_store}); end
    checks++; if ({pc_wb, int_mask, fp_mask} !== 96'd0) begin
      errors++; $display("FAIL reset_pc_masks: got %h exp 0", {pc_wb, int_mask, fp_mask}); end
    @(negedge clk); rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_other();
    offer(WB_INSTR_OTHER, 32'h100, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (ready_wb !== 1'b1) begin errors++; $display("FAIL other_ready: got %b exp 1", ready_wb); end
    tick(); idle(); #1;
    checks++; if ({instr_done, rf_we_wb, rf_waddr_wb, rf_wdata_wb} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL other_write: got done=%b we=%b a=%0d d=%h exp 1 1 5 00001234",
                         instr_done, rf_we_wb, rf_waddr_wb, rf_wdata_wb); end
    checks++; if ({pc_wb, int_mask} !== {32'h100, 32'h20}) begin
      errors++; $display("FAIL other_pc_mask: got pc=%h mask=%h exp 00000100 00000020", pc_wb, int_mask); end
    tick();
    checks++; if ({occupancy, instr_done, int_mask} !== {3'd0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL other_drained: got occ=%0d done=%b mask=%h exp 0 0 0", occupancy, instr_done, int_mask); end
  endtask

  task automatic test_full();
    logic [4:0] exp_rd [4];
    exp_rd = '{5'd2, 5'd3, 5'd4, 5'd6};
    for (int i = 0; i < 4; i++) begin
      offer(WB_INSTR_LOAD, 32'h200 + 32'(4 * i), 5'(i + 1), 32'd0, 1'b1, 1'b0, 1'b0); #1;
      checks++; if (ready_wb !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b exp 1", i, ready_wb); end
      tick();
    end
    idle(); #1;
    checks++; if ({ready_wb, occupancy, instr_done, out_load} !== {1'b0, 3'd4, 1'b0, 1'b1}) begin
      errors++; $display("FAIL full_state: got ready=%b occ=%0d done=%b oload=%b exp 0 4 0 1",
                         ready_wb, occupancy, instr_done, out_load); end
    checks++; if (int_mask !== 32'h1E) begin errors++; $display("FAIL full_mask: got %h exp 0000001e", int_mask); end
    offer(WB_INSTR_LOAD, 32'h210, 5'd6, 32'd0, 1'b1, 1'b0, 1'b0);
    respond(32'hAA, 1'b0); #1;
    checks++; if ({ready_wb, instr_done, rf_waddr_wb, rf_wdata_wb, pc_wb} !== {1'b1, 1'b1, 5'd1, 32'hAA, 32'h200}) begin
      errors++; $display("FAIL full_swap: got ready=%b done=%b a=%0d d=%h pc=%h exp 1 1 1 000000aa 00000200",
                         ready_wb, instr_done, rf_waddr_wb, rf_wdata_wb, pc_wb); end
    tick(); idle(); #1;
    checks++; if ({occupancy, int_mask} !== {3'd4, 32'h5C}) begin
      errors++; $display("FAIL full_after_swap: got occ=%0d mask=%h exp 4 0000005c", occupancy, int_mask); end
    for (int i = 0; i < 4; i++) begin
      respond(32'hB0 + 32'(i), 1'b0); #1;
      checks++; if ({instr_done, rf_we_wb, rf_waddr_wb, rf_wdata_wb} !== {1'b1, 1'b1, exp_rd[i], 32'hB0 + 32'(i)}) begin
        errors++; $display("FAIL drain%0d: got done=%b we=%b a=%0d d=%h exp 1 1 %0d %h",
                           i, instr_done, rf_we_wb, rf_waddr_wb, rf_wdata_wb, exp_rd[i], 32'hB0 + 32'(i)); end
      tick();
    end
    idle(); #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL drain_occ: got %0d exp 0", occupancy); end
  endtask

  task automatic test_load_then_other();
    offer(WB_INSTR_LOAD, 32'h300, 5'd7, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    offer(WB_INSTR_OTHER, 32'h304, 5'd8, 32'h55, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL lto_wait1: got %b exp 0", instr_done); end
    tick(); idle(); #1;
    checks++; if ({instr_done, out_load, occupancy} !== {1'b0, 1'b1, 3'd2}) begin
      errors++; $display("FAIL lto_wait2: got done=%b oload=%b occ=%0d exp 0 1 2", instr_done, out_load, occupancy); end
    tick();
    respond(32'hCAFE, 1'b0); #1;
    checks++; if ({instr_done, rf_we_wb, rf_waddr_wb, rf_wdata_wb, pc_wb} !== {1'b1, 1'b1, 5'd7, 32'hCAFE, 32'h300}) begin
      errors++; $display("FAIL lto_load: got done=%b we=%b a=%0d d=%h pc=%h exp 1 1 7 0000cafe 00000300",
                         instr_done, rf_we_wb, rf_waddr_wb, rf_wdata_wb, pc_wb); end
    tick(); idle(); #1;
    checks++; if ({instr_done, rf_waddr_wb, rf_wdata_wb, pc_wb} !== {1'b1, 5'd8, 32'h55, 32'h304}) begin
      errors++; $display("FAIL lto_other: got done=%b a=%0d d=%h pc=%h exp 1 8 00000055 00000304",
                         instr_done, rf_waddr_wb, rf_wdata_wb, pc_wb); end
    tick();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL lto_occ: got %0d exp 0", occupancy); end
  endtask

  task automatic test_capture();
    offer(WB_INSTR_LOAD, 32'h400, 5'd11, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    offer(WB_INSTR_OTHER, 32'h404, 5'd9, 32'h11, 1'b1, 1'b0, 1'b0);
    tick();
    offer(WB_INSTR_LOAD, 32'h408, 5'd10, 32'd0, 1'b1, 1'b0, 1'b0);
    respond(32'h77, 1'b0); #1;
    checks++; if ({instr_done, rf_waddr_wb, rf_wdata_wb} !== {1'b1, 5'd11, 32'h77}) begin
      errors++; $display("FAIL cap_first: got done=%b a=%0d d=%h exp 1 11 00000077", instr_done, rf_waddr_wb, rf_wdata_wb); end
    tick(); idle();
    respond(32'h88, 1'b0); #1;
    checks++; if ({instr_done, rf_waddr_wb, rf_wdata_wb, pc_wb} !== {1'b1, 5'd9, 32'h11, 32'h404}) begin
      errors++; $display("FAIL cap_other: got done=%b a=%0d d=%h pc=%h exp 1 9 00000011 00000404",
                         instr_done, rf_waddr_wb, rf_wdata_wb, pc_wb); end
    tick(); idle(); #1;
    checks++; if ({instr_done, rf_waddr_wb, rf_wdata_wb, pc_wb, out_load} !== {1'b1, 5'd10, 32'h88, 32'h408, 1'b0}) begin
      errors++; $display("FAIL cap_load: got done=%b a=%0d d=%h pc=%h oload=%b exp 1 10 00000088 00000408 0",
                         instr_done, rf_waddr_wb, rf_wdata_wb, pc_wb, out_load); end
    tick();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL cap_occ: got %0d exp 0", occupancy); end
  endtask

  task automatic test_fp_err();
    offer(WB_INSTR_LOAD, 32'h500, 5'd3, 32'd0, 1'b0, 1'b0, 1'b1);
    tick(); idle(); #1;
    checks++; if ({fp_mask, int_mask} !== {32'h8, 32'h0}) begin
      errors++; $display("FAIL fperr_masks: got fp=%h int=%h exp 00000008 00000000", fp_mask, int_mask); end
    respond(32'hDEAD, 1'b1); #1;
    checks++; if ({instr_done, rf_we_wb, fp_rf_wen_wb, perf_ret, perf_ret_c} !== 5'b10000) begin
      errors++; $display("FAIL fperr_retire: got done/we/fwe/perf/perfc=%b exp 10000",
                         {instr_done, rf_we_wb, fp_rf_wen_wb, perf_ret, perf_ret_c}); end
    tick(); idle(); #1;
    checks++; if ({fp_mask, occupancy} !== {32'h0, 3'd0}) begin
      errors++; $display("FAIL fperr_clear: got fp=%h occ=%0d exp 0 0", fp_mask, occupancy); end
  endtask

  task automatic test_x0();
    offer(WB_INSTR_OTHER, 32'h600, 5'd0, 32'h99, 1'b1, 1'b0, 1'b0);
    tick(); idle(); #1;
    checks++; if ({instr_done, rf_we_wb, int_mask} !== {1'b1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL x0: got done=%b we=%b mask=%h exp 1 0 0", instr_done, rf_we_wb, int_mask); end
    tick();
  endtask

  task automatic test_store();
    offer(WB_INSTR_STORE, 32'h700, 5'd13, 32'h5, 1'b0, 1'b0, 1'b0);
    tick(); idle(); #1;
    checks++; if ({out_store, out_load, instr_done, int_mask} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL store_wait: got ostore=%b oload=%b done=%b mask=%h exp 1 0 0 0",
                         out_store, out_load, instr_done, int_mask); end
    respond(32'h1, 1'b0); #1;
    checks++; if ({instr_done, rf_we_wb, fp_rf_wen_wb, pc_wb} !== {1'b1, 1'b0, 1'b0, 32'h700}) begin
      errors++; $display("FAIL store_retire: got done=%b we=%b fwe=%b pc=%h exp 1 0 0 00000700",
                         instr_done, rf_we_wb, fp_rf_wen_wb, pc_wb); end
    tick(); idle(); #1;
    checks++; if ({out_store, occupancy} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL store_done: got ostore=%b occ=%0d exp 0 0", out_store, occupancy); end
  endtask

  task automatic test_reset_mid();
    offer(WB_INSTR_LOAD, 32'h800, 5'd12, 32'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    respond(32'h42, 1'b0);
    rst_ni = 1'b0; #1;
    checks++; if ({occupancy, instr_done, rf_we_wb, ready_wb, int_mask} !== {3'd0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
      errors++; $display("FAIL rstmid: got occ=%0d done=%b we=%b ready=%b mask=%h exp 0 0 0 1 0",
                         occupancy, instr_done, rf_we_wb, ready_wb, int_mask); end
    tick();
    rst_ni = 1'b1; idle();
    tick();
    checks++; if ({occupancy, out_load, instr_done, pc_wb} !== {3'd0, 1'b0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL rstmid_after: got occ=%0d oload=%b done=%b pc=%h exp 0 0 0 0",
                         occupancy, out_load, instr_done, pc_wb); end
  endtask

  initial begin
    idle();
    test_reset();
    test_other();
    test_full();
    test_load_then_other();
    test_capture();
    test_fp_err();
    test_x0();
    test_store();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish exp finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
